// File: rtl/snake_dir_ctrl.sv
// Snake head direction sequencer: button edge capture, step pacing, one buffered
// turn per step with reversal blocking, and the idle/run/paused/dead game FSM.
module snake_dir_ctrl #(
   parameter int TICK_DIV = 25_000_000,
   parameter int CNT_W    = 25
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_r,
   input  logic       btn_l,
   input  logic       btn_u,
   input  logic       btn_d,
   input  logic       pause,
   input  logic       game_over,
   input  logic       restart,
   output logic [2:0] bcd,
   output logic       step,
   output logic [1:0] state
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;
   localparam logic [1:0] ST_DEAD  = 2'd3;

   localparam logic [2:0]       DIR_STOP = 3'd4;
   localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TICK_DIV - 1);

   logic [1:0]       r_state;
   logic [2:0]       r_bcd;
   logic             r_step;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_pend;
   logic             r_pend_vld;
   logic [3:0]       r_btn_q;

   logic [3:0] w_btn;
   logic [3:0] w_edge;
   logic       w_press;
   logic [1:0] w_dir;
   logic       w_term;
   logic [2:0] w_bcd_base;
   logic       w_pvld_base;
   logic       w_accept;

   // A turn is legal only onto the other axis: same or opposite share bit 1.
   function automatic logic turn_ok(input logic [1:0] dir, input logic [2:0] cur);
      return cur[2] || (dir[1] != cur[1]);
   endfunction

   // Button vector is ordered {u, d, l, r}.
   assign w_btn   = {btn_u, btn_d, btn_l, btn_r};
   assign w_edge  = w_btn & ~r_btn_q;
   assign w_press = |w_edge;

   always_comb begin
      w_dir = 2'd0;
      if (w_edge[3])      w_dir = 2'd2;
      else if (w_edge[2]) w_dir = 2'd3;
      else if (w_edge[1]) w_dir = 2'd1;
      else                w_dir = 2'd0;
   end

   // On the step edge the pending turn is applied first, so a press on that same
   // cycle is judged against the new heading and can become the next pending turn.
   assign w_term      = (r_cnt == CNT_TERM);
   assign w_bcd_base  = (w_term && r_pend_vld) ? {1'b0, r_pend} : r_bcd;
   assign w_pvld_base = r_pend_vld & ~w_term;
   assign w_accept    = w_press && !w_pvld_base && turn_ok(w_dir, w_bcd_base);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_bcd      <= DIR_STOP;
         r_step     <= 1'b0;
         r_cnt      <= '0;
         r_pend     <= 2'd0;
         r_pend_vld <= 1'b0;
         r_btn_q    <= 4'd0;
      end else begin
         r_btn_q <= w_btn;
         r_step  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_press) begin
                  r_state <= ST_RUN;
                  r_bcd   <= {1'b0, w_dir};
                  r_cnt   <= '0;
               end
            end
            ST_RUN: begin
               if (game_over) begin
                  r_state    <= ST_DEAD;
                  r_bcd      <= DIR_STOP;
                  r_pend_vld <= 1'b0;
                  r_cnt      <= '0;
               end else if (pause) begin
                  r_state <= ST_PAUSE;
               end else begin
                  r_cnt      <= w_term ? '0 : r_cnt + 1'b1;
                  r_step     <= w_term;
                  r_bcd      <= w_bcd_base;
                  r_pend_vld <= w_pvld_base;
                  if (w_accept) begin
                     r_pend     <= w_dir;
                     r_pend_vld <= 1'b1;
                  end
               end
            end
            ST_PAUSE: begin
               if (game_over) begin
                  r_state    <= ST_DEAD;
                  r_bcd      <= DIR_STOP;
                  r_pend_vld <= 1'b0;
                  r_cnt      <= '0;
               end else if (!pause) begin
                  r_state <= ST_RUN;
               end
            end
            default: begin
               if (restart) r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bcd   = r_bcd;
   assign step  = r_step;
   assign state = r_state;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Bench for snake_dir_ctrl: directed scenarios plus randomized play, all checked
// against a cycle-level behavioural model of the game rules.
module tb_snake_dir_ctrl;

   localparam int TD = 4;
   localparam int CW = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_r = 1'b0, btn_l = 1'b0, btn_u = 1'b0, btn_d = 1'b0;
   logic       pause = 1'b0, game_over = 1'b0, restart = 1'b0;
   logic [2:0] bcd;
   logic       step;
   logic [1:0] state;

   int total = 0;
   int bad   = 0;

   // Behavioural model: directions indexed r=0, l=1, u=2, d=3.
   logic [1:0] m_state;
   logic [2:0] m_bcd;
   logic       m_step;
   int         m_cnt;
   int         m_pend[$];
   bit         m_prev[4];

   snake_dir_ctrl #(.TICK_DIV(TD), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .btn_r(btn_r), .btn_l(btn_l), .btn_u(btn_u), .btn_d(btn_d),
      .pause(pause), .game_over(game_over), .restart(restart),
      .bcd(bcd), .step(step), .state(state)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_state = 2'd0;
      m_bcd   = 3'd4;
      m_step  = 1'b0;
      m_cnt   = 0;
      m_pend.delete();
      for (int i = 0; i < 4; i++) m_prev[i] = 1'b0;
   endtask

   task automatic model_edge();
      bit now[4];
      int pick;
      now[0] = btn_r; now[1] = btn_l; now[2] = btn_u; now[3] = btn_d;
      pick = -1;
      if (now[2] && !m_prev[2])      pick = 2;
      else if (now[3] && !m_prev[3]) pick = 3;
      else if (now[1] && !m_prev[1]) pick = 1;
      else if (now[0] && !m_prev[0]) pick = 0;
      for (int i = 0; i < 4; i++) m_prev[i] = now[i];
      m_step = 1'b0;
      case (m_state)
         2'd0: if (pick >= 0) begin
            m_state = 2'd1; m_bcd = 3'(pick); m_cnt = 0;
         end
         2'd1: begin
            if (game_over) begin
               m_state = 2'd3; m_bcd = 3'd4; m_cnt = 0; m_pend.delete();
            end else if (pause) begin
               m_state = 2'd2;
            end else begin
               m_cnt++;
               if (m_cnt == TD) begin
                  m_cnt  = 0;
                  m_step = 1'b1;
                  if (m_pend.size() > 0) m_bcd = 3'(m_pend.pop_front());
               end
               if (pick >= 0 && m_pend.size() == 0 && (pick / 2) != (int'(m_bcd) / 2))
                  m_pend.push_back(pick);
            end
         end
         2'd2: begin
            if (game_over) begin
               m_state = 2'd3; m_bcd = 3'd4; m_cnt = 0; m_pend.delete();
            end else if (!pause) begin
               m_state = 2'd1;
            end
         end
         default: if (restart) m_state = 2'd0;
      endcase
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         model_edge();
         #1;
      end
   endtask

   task automatic release_btns();
      btn_r = 1'b0; btn_l = 1'b0; btn_u = 1'b0; btn_d = 1'b0;
   endtask

   task automatic test_reset();
      model_reset();
      rst_n = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      total++;
      if (bcd !== 3'd4 || state !== 2'd0 || step !== 1'b0) begin
         $display("FAIL reset: bcd=%0d state=%0d step=%0d, want 4/0/0", bcd, state, step);
         bad++;
      end
      rst_n = 1'b1;
      tick(2);
      total++;
      if (bcd !== 3'd4 || state !== 2'd0) begin
         $display("FAIL idle_hold: bcd=%0d state=%0d, want 4/0", bcd, state);
         bad++;
      end
   endtask

   task automatic test_start();
      btn_r = 1'b1;
      tick();
      total++;
      if (state !== 2'd1 || bcd !== 3'd0) begin
         $display("FAIL start: state=%0d bcd=%0d, want 1/0", state, bcd);
         bad++;
      end
      release_btns();
      for (int k = 1; k <= 12; k++) begin
         tick();
         total++;
         if (step !== ((k % 4) == 0) || step !== m_step) begin
            $display("FAIL step_pace k=%0d: step=%0d, want %0d", k, step, (k % 4) == 0);
            bad++;
         end
      end
   endtask

   // Entered right after a step edge, with counter back at 0 and bcd=0.
   task automatic test_turns();
      bit seen;
      btn_l = 1'b1; tick(); release_btns();
      total++;
      if (bcd !== 3'd0) begin
         $display("FAIL reverse_ignored: bcd=%0d, want 0", bcd);
         bad++;
      end
      btn_u = 1'b1; tick(); release_btns();
      seen = 1'b0;
      for (int k = 0; k < 6 && !seen; k++) begin
         tick();
         total++;
         if (step === 1'b1) begin
            seen = 1'b1;
            if (bcd !== 3'd2) begin
               $display("FAIL turn_up_at_step: bcd=%0d, want 2", bcd);
               bad++;
            end
         end else if (bcd !== 3'd0) begin
            $display("FAIL turn_early: bcd=%0d before step, want 0", bcd);
            bad++;
         end
      end
      if (!seen) begin
         $display("FAIL turn_timeout: no step within 6 cycles, want 1");
         bad++; total++;
      end
      btn_r = 1'b1; tick(); release_btns();
      btn_l = 1'b1; tick(); release_btns();
      tick(2);
      total++;
      if (step !== 1'b1 || bcd !== 3'd0) begin
         $display("FAIL first_turn_wins: step=%0d bcd=%0d, want 1/0", step, bcd);
         bad++;
      end
      tick(4);
      total++;
      if (step !== 1'b1 || bcd !== 3'd0) begin
         $display("FAIL dropped_turn: step=%0d bcd=%0d, want 1/0", step, bcd);
         bad++;
      end
   endtask

   // Entered right after a step edge; two more edges bring the counter to 2.
   task automatic test_pause();
      logic [2:0] held;
      tick(2);
      held = bcd;
      pause = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         total++;
         if (step !== 1'b0 || bcd !== held || state !== 2'd2) begin
            $display("FAIL paused k=%0d: step=%0d bcd=%0d state=%0d, want 0/%0d/2",
                     k, step, bcd, state, held);
            bad++;
         end
      end
      btn_u = 1'b1; tick(); release_btns();
      pause = 1'b0;
      tick();
      total++;
      if (state !== 2'd1 || step !== 1'b0) begin
         $display("FAIL unpause: state=%0d step=%0d, want 1/0", state, step);
         bad++;
      end
      tick();
      total++;
      if (step !== 1'b0) begin
         $display("FAIL resume_count: step=%0d, want 0", step);
         bad++;
      end
      tick();
      total++;
      if (step !== 1'b1 || bcd !== held) begin
         $display("FAIL resume_step: step=%0d bcd=%0d, want 1/%0d", step, bcd, held);
         bad++;
      end
   endtask

   // Entered right after a step edge; three edges bring the counter to terminal.
   task automatic test_game_over();
      tick(3);
      game_over = 1'b1; tick(); game_over = 1'b0;
      total++;
      if (step !== 1'b0 || state !== 2'd3 || bcd !== 3'd4) begin
         $display("FAIL game_over: step=%0d state=%0d bcd=%0d, want 0/3/4", step, state, bcd);
         bad++;
      end
      btn_d = 1'b1; tick(); btn_l = 1'b1; tick(); release_btns(); tick();
      total++;
      if (state !== 2'd3 || bcd !== 3'd4 || step !== 1'b0) begin
         $display("FAIL dead_frozen: state=%0d bcd=%0d step=%0d, want 3/4/0", state, bcd, step);
         bad++;
      end
      restart = 1'b1; tick(); restart = 1'b0;
      total++;
      if (state !== 2'd0 || bcd !== 3'd4) begin
         $display("FAIL restart: state=%0d bcd=%0d, want 0/4", state, bcd);
         bad++;
      end
      btn_u = 1'b1; btn_r = 1'b1; tick(); release_btns();
      total++;
      if (state !== 2'd1 || bcd !== 3'd2) begin
         $display("FAIL press_priority: state=%0d bcd=%0d, want 1/2", state, bcd);
         bad++;
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 5) == 0) btn_r = ~btn_r;
         if ($urandom_range(0, 5) == 0) btn_l = ~btn_l;
         if ($urandom_range(0, 5) == 0) btn_u = ~btn_u;
         if ($urandom_range(0, 5) == 0) btn_d = ~btn_d;
         if ($urandom_range(0, 19) == 0) pause = ~pause;
         game_over = ($urandom_range(0, 49) == 0);
         restart   = ($urandom_range(0, 7) == 0);
         tick();
         total++;
         if (state !== m_state || bcd !== m_bcd || step !== m_step || bcd > 3'd4) begin
            $display("FAIL random k=%0d: state/bcd/step=%0d/%0d/%0d, want %0d/%0d/%0d",
                     k, state, bcd, step, m_state, m_bcd, m_step);
            bad++;
         end
      end
      pause = 1'b0; game_over = 1'b0; restart = 1'b0;
      release_btns();
   endtask

   task automatic test_async_reset();
      bit seen;
      tick();
      game_over = 1'b1; tick(); game_over = 1'b0;
      restart = 1'b1; tick(); restart = 1'b0;
      btn_d = 1'b1; tick(); release_btns();
      seen = 1'b0;
      for (int k = 0; k < 8 && !seen; k++) begin
         tick();
         if (step === 1'b1) seen = 1'b1;
      end
      total++;
      if (!seen || state !== 2'd1 || bcd !== 3'd3) begin
         $display("FAIL pre_reset_run: seen=%0d state=%0d bcd=%0d, want 1/1/3", seen, state, bcd);
         bad++;
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (bcd !== 3'd4 || state !== 2'd0 || step !== 1'b0) begin
         $display("FAIL async_reset: bcd=%0d state=%0d step=%0d, want 4/0/0", bcd, state, step);
         bad++;
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      tick(3);
      total++;
      if (state !== m_state || bcd !== m_bcd || step !== m_step) begin
         $display("FAIL post_reset: state=%0d bcd=%0d step=%0d, want %0d/%0d/%0d",
                  state, bcd, step, m_state, m_bcd, m_step);
         bad++;
      end
   endtask

   initial begin
      test_reset();
      test_start();
      test_turns();
      test_pause();
      test_game_over();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
